// File: rtl/mem_stage_pkg.sv
// Shared encodings for the memory stage: access size/sign, writeback select, FSM state.
// Also holds the W-register bundle and the alignment rule used by the stage.
package mem_stage_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam int         F3_UNSIGNED_BIT = 2;

  localparam logic [1:0] SEL_RES = 2'b00;
  localparam logic [1:0] SEL_PC4 = 2'b01;
  localparam logic [1:0] SEL_LD  = 2'b10;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  typedef struct packed {
    logic        valid;
    logic        reg_wr;
    logic [1:0]  sel_ld;
    logic [4:0]  rd;
    logic [31:0] result;
    logic [31:0] dm_rd;
    logic [31:0] pcp4;
    logic        misalign;
    logic        dm_err;
  } wb_t;

  // Size code 11 has no legal alignment, so it is always reported misaligned.
  function automatic logic is_aligned(input logic [1:0] sz, input logic [1:0] lo);
    case (sz)
      SZ_B:    return 1'b1;
      SZ_H:    return ~lo[0];
      SZ_W:    return (lo == 2'b00);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory bus between the memory stage (master) and the data memory (slave).
// Request is held with stable address/data/enables until dm_ack.
interface mem_stage_if;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_be;
  logic        dm_ack;
  logic [31:0] dm_rdata;

  modport master (output dm_req, dm_we, dm_addr, dm_wdata, dm_be,
                  input  dm_ack, dm_rdata);
  modport slave  (input  dm_req, dm_we, dm_addr, dm_wdata, dm_be,
                  output dm_ack, dm_rdata);
endinterface

// File: rtl/mem_stage_load_align.sv
// Combinational load aligner: picks the byte/halfword lane and sign/zero extends.
// Zero latency, no backpressure.
module load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        uns;

  always_comb begin
    byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    uns      = funct3[F3_UNSIGNED_BIT];
    data     = rdata;
    case (funct3[1:0])
      SZ_B:    data = {{24{~uns & byte_sel[7]}}, byte_sel};
      SZ_H:    data = {{16{~uns & half_sel[15]}}, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: issues data-memory accesses, registers results into the W stage (1 cycle min).
// Holds the upstream pipe with stall_mem until dm_ack or TIMEOUT; misaligned ops bypass the bus.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        validM,
  input  logic [31:0] resultM,
  input  logic [31:0] wdM,
  input  logic [2:0]  funct3M,
  input  logic        mem_rdM,
  input  logic        mem_wrM,
  input  logic        reg_wrM,
  input  logic [1:0]  sel_ldM,
  input  logic [4:0]  rdM,
  input  logic [31:0] PCp4M,
  mem_stage_if.master dm,
  output logic        validW,
  output logic        reg_wrW,
  output logic [1:0]  sel_ldW,
  output logic [4:0]  rdW,
  output logic [31:0] resultW,
  output logic [31:0] dm_rdW,
  output logic [31:0] PCp4W,
  output logic        misalignW,
  output logic        dm_errW,
  output logic        stall_mem
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  wb_t            wb_q, wb_d;
  logic           mem_op, aligned, mem_ok, timeout, req;
  logic [3:0]     st_be;
  logic [31:0]    st_wdata, ld_data;

  assign mem_op    = validM & (mem_rdM | mem_wrM);
  assign aligned   = is_aligned(funct3M[1:0], resultM[1:0]);
  assign mem_ok    = mem_op & aligned;
  assign timeout   = (state_q == S_WAIT) && (cnt_q == CW'(TIMEOUT - 1));
  assign req       = ~rst & mem_ok;
  assign stall_mem = req & ~dm.dm_ack & ~timeout;

  // Store lane steering; the request fields depend only on held M inputs, so they stay stable in WAIT.
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = wdM;
    case (funct3M[1:0])
      SZ_B: begin
        st_be    = 4'b0001 << resultM[1:0];
        st_wdata = {4{wdM[7:0]}};
      end
      SZ_H: begin
        st_be    = 4'b0011 << {resultM[1], 1'b0};
        st_wdata = {2{wdM[15:0]}};
      end
      default: ;
    endcase
  end

  assign dm.dm_req   = req;
  assign dm.dm_we    = req & mem_wrM;
  assign dm.dm_be    = req ? st_be : 4'b0000;
  assign dm.dm_addr  = {resultM[31:2], 2'b00};
  assign dm.dm_wdata = st_wdata;

  load_align u_load_align (
    .rdata   (dm.dm_rdata),
    .addr_lo (resultM[1:0]),
    .funct3  (funct3M),
    .data    (ld_data)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (mem_ok && !dm.dm_ack) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        if (!mem_ok || dm.dm_ack || timeout) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wb_d = wb_q;
    if (stall_mem) begin
      wb_d.valid    = 1'b0;
      wb_d.reg_wr   = 1'b0;
      wb_d.misalign = 1'b0;
      wb_d.dm_err   = 1'b0;
    end else begin
      wb_d.valid    = validM;
      wb_d.misalign = mem_op & ~aligned;
      // An ack landing on the timeout cycle still wins: the data is good.
      wb_d.dm_err   = mem_ok & timeout & ~dm.dm_ack;
      wb_d.reg_wr   = validM & reg_wrM & ~wb_d.misalign & ~wb_d.dm_err;
      wb_d.sel_ld   = sel_ldM;
      wb_d.rd       = rdM;
      wb_d.result   = resultM;
      wb_d.pcp4     = PCp4M;
      if (mem_ok && !mem_wrM && dm.dm_ack) begin
        wb_d.dm_rd = ld_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wb_q    <= wb_d;
    end
  end

  assign validW    = wb_q.valid;
  assign reg_wrW   = wb_q.reg_wr;
  assign sel_ldW   = wb_q.sel_ld;
  assign rdW       = wb_q.rd;
  assign resultW   = wb_q.result;
  assign dm_rdW    = wb_q.dm_rd;
  assign PCp4W     = wb_q.pcp4;
  assign misalignW = wb_q.misalign;
  assign dm_errW   = wb_q.dm_err;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vector table, hand sequences, randomized ops vs. model.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        validM, mem_rdM, mem_wrM, reg_wrM;
  logic [31:0] resultM, wdM, PCp4M;
  logic [2:0]  funct3M;
  logic [1:0]  sel_ldM;
  logic [4:0]  rdM;
  logic        validW, reg_wrW, misalignW, dm_errW, stall_mem;
  logic [1:0]  sel_ldW;
  logic [4:0]  rdW;
  logic [31:0] resultW, dm_rdW, PCp4W;

  mem_stage_if dm_if ();

  mem_stage #(.TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .validM    (validM),
    .resultM   (resultM),
    .wdM       (wdM),
    .funct3M   (funct3M),
    .mem_rdM   (mem_rdM),
    .mem_wrM   (mem_wrM),
    .reg_wrM   (reg_wrM),
    .sel_ldM   (sel_ldM),
    .rdM       (rdM),
    .PCp4M     (PCp4M),
    .dm        (dm_if.master),
    .validW    (validW),
    .reg_wrW   (reg_wrW),
    .sel_ldW   (sel_ldW),
    .rdW       (rdW),
    .resultW   (resultW),
    .dm_rdW    (dm_rdW),
    .PCp4W     (PCp4W),
    .misalignW (misalignW),
    .dm_errW   (dm_errW),
    .stall_mem (stall_mem)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] last_rd  = 32'h0;

  typedef struct {
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rdata;
    int          ack;
    logic [31:0] exp_be;
    logic [31:0] exp_wd;
    logic [31:0] exp_ld;
  } vec_t;

  vec_t tbl [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference rules written from access size in bytes.
  function automatic logic model_mis(input logic [2:0] f3, input logic [31:0] a);
    int nb = 1 << f3[1:0];
    return (f3[1:0] == 2'b11) || ((a % nb) != 0);
  endfunction

  function automatic logic [31:0] model_be(input logic [2:0] f3, input logic [31:0] a);
    int nb = 1 << f3[1:0];
    return 32'(((1 << nb) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
    int nb = 1 << f3[1:0];
    logic [31:0] mask, val, r;
    if (nb == 4) return wd;
    mask = 32'((1 << (8 * nb)) - 1);
    val  = wd & mask;
    r    = 32'h0;
    for (int k = 0; k < 4 / nb; k++) r = r | (val << (8 * nb * k));
    return r;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rdata);
    int nb = 1 << f3[1:0];
    logic [31:0] mask, v;
    if (nb == 4) return rdata;
    mask = 32'((1 << (8 * nb)) - 1);
    v    = (rdata >> (8 * (a % 4))) & mask;
    if (!f3[2] && v[8 * nb - 1]) v = v | ~mask;
    return v;
  endfunction

  // ack_delay < 0 means the memory never answers.
  task automatic run_op(input string name, input logic mem, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdata,
                        input int ack_delay, input logic [31:0] exp_be, input logic [31:0] exp_wd,
                        input logic [31:0] exp_ld);
    logic        mis, to, rw;
    logic [1:0]  sel;
    logic [4:0]  rd;
    logic [31:0] pc, exp_rd;
    int          stalls;
    @(posedge clk); #1;
    check({name, ":prev_valid"}, 32'(validW), 32'h0);
    check({name, ":pulse_clear"}, 32'({misalignW, dm_errW}), 32'h0);
    mis    = mem && model_mis(f3, addr);
    to     = mem && !mis && (ack_delay < 0);
    stalls = (!mem || mis) ? 0 : ((ack_delay < 0) ? TO : ack_delay);
    rd     = 5'($urandom);
    pc     = $urandom;
    sel    = (mem && !wr) ? SEL_LD : 2'($urandom_range(0, 1));
    rw     = mem ? !wr : 1'($urandom_range(0, 1));
    validM = 1'b1; resultM = addr; wdM = wd; funct3M = f3;
    mem_rdM = mem && !wr; mem_wrM = mem && wr; reg_wrM = rw;
    sel_ldM = sel; rdM = rd; PCp4M = pc; dm_if.dm_rdata = rdata;
    for (int c = 0; c <= stalls; c++) begin
      dm_if.dm_ack = mem && !mis && (c == ack_delay);
      @(negedge clk);
      check({name, ":stall"}, 32'(stall_mem), 32'(c < stalls));
      check({name, ":req"}, 32'(dm_if.dm_req), 32'(mem && !mis));
      if (mem && !mis) begin
        check({name, ":addr"}, dm_if.dm_addr, addr & ~32'h3);
        check({name, ":we"}, 32'(dm_if.dm_we), 32'(wr));
        if (wr) begin
          check({name, ":be"}, 32'(dm_if.dm_be), exp_be);
          check({name, ":wdata"}, dm_if.dm_wdata, exp_wd);
        end
      end
      @(posedge clk); #1;
      if (c < stalls) check({name, ":bubble"}, 32'({validW, reg_wrW}), 32'h0);
    end
    exp_rd  = (mem && !wr && !mis && !to) ? exp_ld : last_rd;
    last_rd = exp_rd;
    check({name, ":validW"}, 32'(validW), 32'h1);
    check({name, ":reg_wrW"}, 32'(reg_wrW), 32'(rw && !mis && !to));
    check({name, ":misalignW"}, 32'(misalignW), 32'(mis));
    check({name, ":dm_errW"}, 32'(dm_errW), 32'(to));
    check({name, ":sel_ldW"}, 32'(sel_ldW), 32'(sel));
    check({name, ":rdW"}, 32'(rdW), 32'(rd));
    check({name, ":resultW"}, resultW, addr);
    check({name, ":PCp4W"}, PCp4W, pc);
    check({name, ":dm_rdW"}, dm_rdW, exp_rd);
    validM = 1'b0; mem_rdM = 1'b0; mem_wrM = 1'b0; dm_if.dm_ack = 1'b0;
  endtask

  initial begin
    logic       r_mem, r_wr;
    logic [2:0] r_f3;
    logic [31:0] r_addr, r_wd, r_rdata;

    tbl[0]  = '{1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0,        0, 32'hF, 32'hDEADBEEF, 32'h0};
    tbl[1]  = '{1'b0, 3'b000, 32'h103, 32'h0,        32'h80FFFF7F, 3, 32'h0, 32'h0,        32'hFFFFFF80};
    tbl[2]  = '{1'b0, 3'b101, 32'h102, 32'h0,        32'hABCD1234, 1, 32'h0, 32'h0,        32'h0000ABCD};
    tbl[3]  = '{1'b0, 3'b010, 32'h101, 32'h0,        32'h11111111, 0, 32'h0, 32'h0,        32'h0};
    tbl[4]  = '{1'b1, 3'b000, 32'h102, 32'h12345678, 32'h0,        2, 32'h4, 32'h78787878, 32'h0};
    tbl[5]  = '{1'b1, 3'b001, 32'h102, 32'h12345678, 32'h0,        0, 32'hC, 32'h56785678, 32'h0};
    tbl[6]  = '{1'b0, 3'b001, 32'h100, 32'h0,        32'h12348001, 4, 32'h0, 32'h0,        32'hFFFF8001};
    tbl[7]  = '{1'b0, 3'b100, 32'h101, 32'h0,        32'h0000F000, 0, 32'h0, 32'h0,        32'h000000F0};
    tbl[8]  = '{1'b1, 3'b001, 32'h103, 32'h0000BEEF, 32'h0,        0, 32'h0, 32'h0,        32'h0};
    tbl[9]  = '{1'b0, 3'b011, 32'h100, 32'h0,        32'h22222222, 0, 32'h0, 32'h0,        32'h0};
    tbl[10] = '{1'b0, 3'b010, 32'h104, 32'h0,        32'hCAFEBABE, 2, 32'h0, 32'h0,        32'hCAFEBABE};
    tbl[11] = '{1'b1, 3'b000, 32'h101, 32'h000000AB, 32'h0,        1, 32'h2, 32'hABABABAB, 32'h0};

    rst = 1'b1;
    validM = 1'b0; resultM = '0; wdM = '0; funct3M = '0; mem_rdM = 1'b0; mem_wrM = 1'b0;
    reg_wrM = 1'b0; sel_ldM = '0; rdM = '0; PCp4M = '0;
    dm_if.dm_ack = 1'b0; dm_if.dm_rdata = '0;
    #2;
    check("rst:validW", 32'({validW, reg_wrW, misalignW, dm_errW}), 32'h0);
    check("rst:sel_rd", 32'({sel_ldW, rdW}), 32'h0);
    check("rst:resultW", resultW, 32'h0);
    check("rst:dm_rdW", dm_rdW, 32'h0);
    check("rst:PCp4W", PCp4W, 32'h0);
    check("rst:bus", 32'({dm_if.dm_req, dm_if.dm_we, dm_if.dm_be, stall_mem}), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 12; i++)
      run_op($sformatf("vec%0d", i), 1'b1, tbl[i].wr, tbl[i].f3, tbl[i].addr, tbl[i].wd,
             tbl[i].rdata, tbl[i].ack, tbl[i].exp_be, tbl[i].exp_wd, tbl[i].exp_ld);

    run_op("alu", 1'b0, 1'b0, 3'b010, 32'h1234, 32'h0, 32'h0, 0, 32'h0, 32'h0, 32'h0);
    run_op("lw_timeout", 1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 32'h55AA55AA, -1,
           32'h0, 32'h0, 32'h0);
    run_op("lw_after_to", 1'b1, 1'b0, 3'b010, 32'h204, 32'h0, 32'h0BADF00D, 0,
           32'h0, 32'h0, 32'h0BADF00D);

    // Stray ack with nothing requested.
    @(posedge clk); #1;
    dm_if.dm_ack = 1'b1;
    @(negedge clk);
    check("stray:req_stall", 32'({dm_if.dm_req, stall_mem}), 32'h0);
    @(posedge clk); #1;
    check("stray:validW", 32'(validW), 32'h0);
    check("stray:dm_rdW", dm_rdW, last_rd);
    dm_if.dm_ack = 1'b0;

    // Reset in the middle of a waiting load, then a late ack.
    @(posedge clk); #1;
    validM = 1'b1; mem_rdM = 1'b1; reg_wrM = 1'b1; funct3M = 3'b010; resultM = 32'h300;
    rdM = 5'd7; PCp4M = 32'h44; sel_ldM = SEL_LD; dm_if.dm_rdata = 32'h12345678;
    repeat (3) @(posedge clk);
    #1;
    check("rstw:stall_pre", 32'(stall_mem), 32'h1);
    rst = 1'b1;
    #1;
    check("rstw:bus", 32'({dm_if.dm_req, dm_if.dm_we, dm_if.dm_be, stall_mem}), 32'h0);
    check("rstw:flags", 32'({validW, reg_wrW, misalignW, dm_errW, sel_ldW, rdW}), 32'h0);
    check("rstw:data", resultW | dm_rdW | PCp4W, 32'h0);
    last_rd = 32'h0;
    validM = 1'b0; mem_rdM = 1'b0; reg_wrM = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    dm_if.dm_ack = 1'b1;
    @(posedge clk); #1;
    check("rstw:late_ack_valid", 32'(validW), 32'h0);
    check("rstw:late_ack_rd", dm_rdW, 32'h0);
    dm_if.dm_ack = 1'b0;

    run_op("lw_after_rst", 1'b1, 1'b0, 3'b010, 32'h308, 32'h0, 32'h600DCAFE, 0,
           32'h0, 32'h0, 32'h600DCAFE);

    for (int i = 0; i < 40; i++) begin
      r_mem   = ($urandom_range(0, 4) != 0);
      r_wr    = 1'($urandom_range(0, 1));
      r_f3    = 3'($urandom_range(0, 7));
      if (r_f3 >= 3'd6) r_f3 = 3'b010;
      if (r_wr) r_f3[2] = 1'b0;
      r_addr  = 32'h1000 + 32'($urandom_range(0, 31));
      r_wd    = $urandom;
      r_rdata = $urandom;
      run_op($sformatf("rnd%0d", i), r_mem, r_wr, r_f3, r_addr, r_wd, r_rdata,
             $urandom_range(0, 5), model_be(r_f3, r_addr), model_wdata(r_f3, r_wd),
             model_load(r_f3, r_addr, r_rdata));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
